seq_chunk_adder: RTL
====================

# seq_chunk_adder

Multi-cycle, parametrised ripple-carry adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock. The inter-chunk carry is held in a register. It replaces a fully combinational wide ripple chain where timing closure, not latency, is the constraint. A start/done handshake gives it a simple interface for datapath controllers.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; NCHUNK = WIDTH/CHUNK (≥1).
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled in IDLE or DONE only.
- a  input  WIDTH  operand A, latched on accepted start.
- b  input  WIDTH  operand B, latched on accepted start.
- cin  input  1  carry-in (borrow-in when sub=1), latched on accepted start.
- sub  input  1  0: A+B+cin; 1: A−B−cin; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result; holds until next done.
- cout  output  1  carry-out; for sub, 1 = no borrow.
- ovf  output  1  signed overflow (only with SEQ_ADDER_OVF_EN).

## Operation
- States: IDLE, RUN, DONE.
- IDLE --start--> RUN. DONE --start--> RUN. DONE --!start--> IDLE. RUN stays in RUN until the last chunk, then goes to DONE.
- On accepted start, the block latches:
  - opA = a;
  - opB = sub ? ~b : b;
  - carry = cin ^ sub (sub=1, cin=0 gives A−B; cin=1 gives A−B−1);
  - idx = 0.
- Each RUN cycle:
  - chunk idx: {c, s} = opA[idx] + opB[idx] + carry, with CHUNK-bit slices;
  - s is written into the accumulator slice idx; carry = c; idx++.
- Last chunk (idx = NCHUNK−1), at the same edge:
  - sum ← accumulator including the final slice;
  - cout ← final carry;
  - state → DONE.
- sum and cout change only at the edge entering DONE. They hold the previous result during RUN.
- start is ignored in RUN. Operand changes during RUN have no effect.
- All arithmetic is modulo 2^WIDTH. There are no sign-extension rules; operands are raw bit vectors.

## Timing
- Accepted start at edge T: busy = 1 from T to T+NCHUNK; done = 1 in the cycle after edge T+NCHUNK.
- Latency from start edge to done is NCHUNK cycles. With NCHUNK = 1, done follows start by one cycle.
- Throughput: start asserted during DONE gives back-to-back operations of NCHUNK+1 cycles each, with no IDLE gap.
- done and busy are registered and never high together.
- Reset values: state IDLE, busy 0, done 0, sum 0, cout 0, ovf 0, internal carry/idx/accumulator 0.
- Reset asserted mid-RUN aborts immediately:
  - no done is produced;
  - sum and cout go to 0;
  - the first start after deassertion is accepted normally.

## Configuration
- SEQ_ADDER_OVF_EN defined:
  - the ovf port exists;
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1, for the final chunk;
  - registered with sum, cleared on reset, held until the next done.
- SEQ_ADDER_OVF_EN undefined: no ovf port and no MSB-carry logic.

## Structure
- Package seq_adder_pkg holds:
  - the state enum type (IDLE, RUN, DONE);
  - a localparam function computing NCHUNK and the idx width ($clog2(NCHUNK), minimum 1).
- Sub-module chunk_adder: combinational CHUNK-bit ripple of full adders.
  - Outputs the sum slice, carry-out, and carry into the MSB (the last is used for ovf).
  - Instantiated once; it is time-multiplexed across chunks.
- Elaboration check: error if WIDTH % CHUNK != 0.

## Test plan
All tests use WIDTH=8, CHUNK=4 (NCHUNK=2) unless noted.
- Chunk carry: a=0x0F, b=0x00, cin=1, sub=0 → sum=0x10, cout=0. done two cycles after the start edge; busy high for exactly two cycles.
- Wrap: a=0xFF, b=0x01, cin=0, sub=0 → sum=0x00, cout=1. With OVF_EN: a=0x7F, b=0x01 → sum=0x80, ovf=1.
- Subtract: a=0x05, b=0x07, sub=1, cin=0 → sum=0xFE, cout=0. Then a=0x07, b=0x05 → sum=0x02, cout=1. With cin=1 → sum=0x01.
- Handshake:
  - start re-pulsed during RUN with different operands is ignored; the result matches the first operands;
  - start held during DONE launches the next operation with no IDLE cycle.
- Reset: rst_n low during the first RUN cycle → busy, done, sum, cout = 0 immediately; no done follows. The next start completes correctly.
- Randomised sweep at WIDTH=32 with CHUNK ∈ {1, 4, 32}: compare sum and cout against a reference model computing a±b±cin.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the chunked sequential adder.
// Optional signed-overflow output is enabled by SEQ_ADDER_OVF_EN.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(int w, int c);
    return w / c;
  endfunction

  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Start/done handshake and operand/result bus of the sequential adder.
// The ovf signal exists only when SEQ_ADDER_OVF_EN is defined.
interface seq_chunk_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SEQ_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, ovf
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, ovf
  );
`else
  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout
  );
  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout
  );
`endif
endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// Combinational CHUNK-bit ripple of full adders, shared by all chunks.
// Carry into the MSB is exported only when SEQ_ADDER_OVF_EN is defined.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
`ifdef SEQ_ADDER_OVF_EN
  output logic             cm_o,
`endif
  output logic [CHUNK-1:0] s_o,
  output logic             c_o
);
  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = c_i;
    for (int i = 0; i < CHUNK; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign c_o  = c[CHUNK];
`ifdef SEQ_ADDER_OVF_EN
  assign cm_o = c[CHUNK-1];
`endif
endmodule

// File: rtl/seq_chunk_adder.sv
// WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Define SEQ_ADDER_OVF_EN to add the registered signed-overflow output.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic clk,
  input  logic rst_n,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_w(NCHUNK);

  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic [CHUNK-1:0] ca_s;
  logic             ca_co;
  logic             last;
  int               base;

  assign base = CHUNK * int'(idx_q);
  assign last = (idx_q == IW'(NCHUNK - 1));

`ifdef SEQ_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  logic ca_cm;
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i  (opa_q[base +: CHUNK]),
    .b_i  (opb_q[base +: CHUNK]),
    .c_i  (carry_q),
`ifdef SEQ_ADDER_OVF_EN
    .cm_o (ca_cm),
`endif
    .s_o  (ca_s),
    .c_o  (ca_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SEQ_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d[base +: CHUNK] = ca_s;
        carry_d = ca_co;
        idx_d   = idx_q + IW'(1);
        if (last) begin
          sum_d   = acc_d;
          cout_d  = ca_co;
`ifdef SEQ_ADDER_OVF_EN
          ovf_d   = ca_cm ^ ca_co;
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SEQ_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif
endmodule
